pool_layer_controller: RTL
==========================

// Module: pool_layer_controller
// PURPOSE
//  Sequences the 2x2 max-pool datapath behind the conv layer. Watches conv valid/feature_idx/feature_row
//  and queues one pool job per completed conv row pair per feature map. Issues jobs to the pool input
//  interface over a cmd/ack handshake and reports per-job results and end of image.
//  Backpressures the conv layer when the job queue nears full.
// PARAMETERS
//  TOTAL_WEIGHT  4  feature maps per conv row (conv_feature_idx range 0..TOTAL_WEIGHT-1)
//  TOTAL_ROW     8  conv output rows per image; must be even; pooled rows = TOTAL_ROW/2
//  JOB_DEPTH     4  pool job queue depth (power of 2, >=2)
// PORTS
//  clk                input   1  system clock, rising edge
//  rst_n              input   1  asynchronous active-low reset
//  enable             input   1  global enable; gates job capture and FSM advance
//  conv_valid         input   1  one-cycle pulse: conv feature row complete
//  conv_feature_idx   input   2  feature map of completed conv row
//  conv_feature_row   input   3  conv row index of completed conv row
//  pool_ack           input   2  pool interface ack; ACK_POOL_FIN = job done
//  pool_cmd           output  2  CMD_IDLE / CMD_POOL to pool interface
//  pool_feature_idx   output  2  feature map of issued/completed job
//  pool_out_row       output  2  pooled row index of issued/completed job (conv_row>>1)
//  pool_valid         output  1  one-cycle pulse: job result written
//  pool_calc_fin      output  1  one-cycle pulse: last job of image complete
//  conv_stall         output  1  backpressure to conv controller
//  overflow_err       output  1  sticky: job dropped on full queue
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
//  Reset: all outputs 0, pool_cmd=CMD_IDLE, queue empty, FSM S_IDLE. Reset mid-job discards the
//   in-flight job; pool datapath shares rst_n.
//  Capture:
//   - push {conv_feature_idx, conv_feature_row[2:1]} when enable & conv_valid & conv_feature_row[0]==1.
//   - even rows never push.
//  Queue:
//   - simultaneous push+pop keeps count; pop happens on accepted ack.
//   - push while count==JOB_DEPTH: job dropped, overflow_err<=1 until reset.
//  conv_stall: registered, 1 while count >= JOB_DEPTH-1, else 0.
//  FSM (Moore cmd decode):
//   - S_IDLE:
//     - enable & count!=0 -> S_ISSUE
//   - S_ISSUE:
//     - pool_cmd=CMD_POOL for exactly this cycle
//     - pool_feature_idx/pool_out_row = queue head, held until next issue
//     - -> S_WAIT (enable low: hold S_ISSUE, cmd IDLE)
//   - S_WAIT:
//     - pool_ack==ACK_POOL_FIN -> pop; last job (idx==TOTAL_WEIGHT-1 & row==TOTAL_ROW/2-1) -> S_DONE,
//       else -> S_IDLE
//     - ack accepted even with enable low
//   - S_DONE:
//     - one cycle, then -> S_IDLE
//  Outputs:
//   - pool_valid=1 in the cycle after accepted ACK_POOL_FIN (state S_IDLE or S_DONE entry); idx/row
//     still show the completed job.
//   - pool_calc_fin=1 only in S_DONE, coincident with that job's pool_valid.
//  Acks outside S_WAIT and ack codes other than ACK_POOL_FIN: ignored.
//  Latency:
//   - conv_valid at cycle N -> CMD_POOL at N+2 (empty queue, enable high).
//   - ack at M -> pool_valid at M+1 -> next CMD_POOL no earlier than M+2.
// STRUCTURE
//  pool_layer_param.v, included like conv_kernel_param.v:
//   CMD_IDLE=2'b00, CMD_POOL=2'b01, ACK_IDLE=2'b00, ACK_POOL_FIN=2'b01, S_IDLE/S_ISSUE/S_WAIT/S_DONE.
//  Sub-module pool_job_fifo:
//   - sync FIFO, width 4, depth JOB_DEPTH
//   - push/pop/count/head ports
//   - controller holds FSM, decode and error logic.
// TESTING
//  1 reset: rst_n low mid-S_WAIT -> all outputs 0, pool_cmd=00, count 0; no pool_valid after release.
//  2 single job: conv_valid idx=2 row=3 at N -> CMD_POOL at N+2 with idx=2 out_row=1; ack at N+5
//    -> pool_valid at N+6.
//  3 even row: conv_valid row=2 -> no push, pool_cmd stays 00 for 10 cycles.
//  4 full image: 16 odd-row pushes with ack 3 cycles after each cmd -> 16 pool_valid in
//    idx/row order; pool_calc_fin once, with idx=3 out_row=3.
//  5 backpressure: ack withheld, 4 pushes -> conv_stall=1 after 3rd; 5th push -> overflow_err=1
//    sticky; simultaneous push+pop keeps count.
//  6 enable low in S_ISSUE -> pool_cmd=00, state held; enable high -> single CMD_POOL; stray ack in
//    S_IDLE ignored.

Source files
------------

// File: rtl/pool_layer_controller_pkg.sv
// pool_layer_controller_pkg: shared handshake codes, FSM states and job format for the pool controller
package pool_layer_controller_pkg;
  localparam logic [1:0] CMD_IDLE     = 2'b00;
  localparam logic [1:0] CMD_POOL     = 2'b01;
  localparam logic [1:0] ACK_IDLE     = 2'b00;
  localparam logic [1:0] ACK_POOL_FIN = 2'b01;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef struct packed {
    logic [1:0] idx;
    logic [1:0] row;
  } job_t;
endpackage

// File: rtl/pool_layer_controller_job_fifo.sv
// pool_job_fifo: synchronous job queue exposing its head entry and occupancy
module pool_job_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign head = mem[rd];
  assign full = count == CW'(DEPTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/pool_layer_controller.sv
// pool_layer_controller: queues one 2x2 max-pool job per finished conv row pair and issues them over cmd/ack
module pool_layer_controller
  import pool_layer_controller_pkg::*;
#(
  parameter int TOTAL_WEIGHT = 4,
  parameter int TOTAL_ROW = 8,
  parameter int JOB_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       conv_valid,
  input  logic [1:0] conv_feature_idx,
  input  logic [2:0] conv_feature_row,
  input  logic [1:0] pool_ack,
  output logic [1:0] pool_cmd,
  output logic [1:0] pool_feature_idx,
  output logic [1:0] pool_out_row,
  output logic       pool_valid,
  output logic       pool_calc_fin,
  output logic       conv_stall,
  output logic       overflow_err
);
  localparam int CW = $clog2(JOB_DEPTH) + 1;
  state_t state, state_nx;
  job_t head;
  logic [CW-1:0] count, count_nx;
  logic full, push, keep, pop, last;
  assign push = enable & conv_valid & conv_feature_row[0];
  assign keep = push & ~full;
  assign pop = (state == S_WAIT) && (pool_ack == ACK_POOL_FIN);
  assign last = pool_feature_idx == 2'(TOTAL_WEIGHT - 1) && pool_out_row == 2'(TOTAL_ROW / 2 - 1);
  assign count_nx = count + CW'(keep) - CW'(pop);
  assign pool_cmd = (state == S_ISSUE && enable) ? CMD_POOL : CMD_IDLE;
  assign pool_calc_fin = state == S_DONE;
  pool_job_fifo #(.WIDTH($bits(job_t)), .DEPTH(JOB_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .din   ({conv_feature_idx, conv_feature_row[2:1]}),
    .head  (head),
    .count (count),
    .full  (full)
  );
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = (enable && count != '0) ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nx = enable ? S_WAIT : S_ISSUE;
      S_WAIT:  state_nx = pop ? (last ? S_DONE : S_IDLE) : S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end
  // job fields latch on issue and stay put so the completion pulse still reports them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      pool_valid <= 1'b0;
      conv_stall <= 1'b0;
      overflow_err <= 1'b0;
      pool_feature_idx <= '0;
      pool_out_row <= '0;
    end else begin
      state <= state_nx;
      pool_valid <= pop;
      conv_stall <= count_nx >= CW'(JOB_DEPTH - 1);
      overflow_err <= overflow_err | (push & full);
      if (state == S_IDLE && state_nx == S_ISSUE) {pool_feature_idx, pool_out_row} <= head;
    end
endmodule
